// File: rtl/multi_pipeline_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pipeline_mixer_if
//  Description : Sample, gain-control and crossfade signals between the
//                codec side, the pipeline bank and multi_pipeline_mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_pipeline_mixer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int N_PIPELINES = 4,
    parameter int SEL_WIDTH   = 2
);
    logic signed [DATA_WIDTH-1:0]             in_sample;
    logic                                     in_sample_valid;
    logic signed [DATA_WIDTH-1:0]             in_sample_out;
    logic                                     in_sample_ready;
    logic        [N_PIPELINES*DATA_WIDTH-1:0] out_samples_in;
    logic                                     out_samples_valid;
    logic signed [DATA_WIDTH-1:0]             out_sample;
    logic                                     out_sample_ready;
    logic signed [DATA_WIDTH-1:0]             data_in;
    logic                                     set_input_gain;
    logic                                     set_output_gain;
    logic                                     swap_pipelines;
    logic        [SEL_WIDTH-1:0]              swap_target;
    logic                                     pipelines_swapping;
    logic        [SEL_WIDTH-1:0]              current_pipeline;

    // Controller / sample source side
    modport master (
        output in_sample, in_sample_valid, out_samples_in, out_samples_valid,
               data_in, set_input_gain, set_output_gain, swap_pipelines, swap_target,
        input  in_sample_out, in_sample_ready, out_sample, out_sample_ready,
               pipelines_swapping, current_pipeline
    );

    // Mixer side
    modport slave (
        input  in_sample, in_sample_valid, out_samples_in, out_samples_valid,
               data_in, set_input_gain, set_output_gain, swap_pipelines, swap_target,
        output in_sample_out, in_sample_ready, out_sample, out_sample_ready,
               pipelines_swapping, current_pipeline
    );
endinterface
`default_nettype wire

// File: rtl/multi_pipeline_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pipeline_mixer
//  Description : Saturating input gain stage plus N-way crossfading output
//                mixer with output gain. One time-shared multiplier per path.
//                Optional macro MULTI_PIPELINE_MIXER_SOFT_GAIN_EN makes gain
//                writes glide toward their new value instead of jumping.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_pipeline_mixer #(
    parameter int DATA_WIDTH  = 16,
    parameter int GAIN_SHIFT  = 4,
    parameter int N_PIPELINES = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int FADE_SHIFT  = 7
) (
    input  wire logic             clk,
    input  wire logic             reset,
    multi_pipeline_mixer_if.slave bus
);
    localparam int c_frac   = DATA_WIDTH - 1 - GAIN_SHIFT;
    localparam int c_prod_w = 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] c_unity = DATA_WIDTH'(1 << c_frac);
    localparam logic signed [DATA_WIDTH-1:0] c_step  = DATA_WIDTH'((1 << c_frac) >> FADE_SHIFT);
    localparam logic signed [DATA_WIDTH-1:0] c_max   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] c_min   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IN_MUL   = 3'd1,
        ST_IN_SAT   = 3'd2,
        ST_OUT_MUL  = 3'd3,
        ST_OUT_SUM  = 3'd4,
        ST_OUT_GAIN = 3'd5,
        ST_GAP      = 3'd6
    } state_t;

    state_t r_state, w_state_nxt;

    // Product >>> c_frac (floor), clamped to the sample range
    function automatic logic signed [DATA_WIDTH-1:0] sat_prod(input logic signed [c_prod_w-1:0] p);
        logic signed [c_prod_w-1:0]   s;
        logic [c_prod_w-DATA_WIDTH:0] top;
        s   = p >>> c_frac;
        top = s[c_prod_w-1:DATA_WIDTH-1];
        if ((&top) || !(|top)) return s[DATA_WIDTH-1:0];
        else if (s[c_prod_w-1]) return c_min;
        else return c_max;
    endfunction

    // Clamp a one-bit-wider sum to the sample range
    function automatic logic signed [DATA_WIDTH-1:0] sat_sum(input logic [DATA_WIDTH:0] v);
        if (v[DATA_WIDTH] == v[DATA_WIDTH-1]) return v[DATA_WIDTH-1:0];
        else if (v[DATA_WIDTH]) return c_min;
        else return c_max;
    endfunction

    // Effective gains
    logic signed [DATA_WIDTH-1:0] r_in_gain, r_out_gain;

    // Crossfade state
    logic [SEL_WIDTH-1:0]         r_current, r_target, r_pend;
    logic                         r_pend_v, r_swapping;
    logic signed [DATA_WIDTH-1:0] r_gcur, r_gtgt;

    // Input path
    logic signed [DATA_WIDTH-1:0] r_in_x, r_in_g, r_in_out;
    logic signed [c_prod_w-1:0]   r_in_prod;
    logic                         r_in_ready;

    // Output path
    logic signed [DATA_WIDTH-1:0] r_ch_a, r_ch_b, r_g_a, r_g_b, r_og;
    logic signed [DATA_WIDTH-1:0] r_part_a, r_sum, r_out;
    logic                         r_out_ready;

    logic signed [DATA_WIDTH-1:0] w_ch [N_PIPELINES];
    logic signed [DATA_WIDTH-1:0] w_mul_x, w_mul_y, w_out_sat;
    logic signed [c_prod_w-1:0]   w_out_prod;
    logic        [DATA_WIDTH:0]   w_sum_wide;
    logic                         w_accept_in, w_accept_out, w_start, w_fade_step, w_req_ok;

    generate
        for (genvar k = 0; k < N_PIPELINES; k++) begin : g_unpack
            assign w_ch[k] = bus.out_samples_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_accept_in  = (r_state == ST_IDLE) && bus.in_sample_valid;
    assign w_accept_out = (r_state == ST_IDLE) && !bus.in_sample_valid && bus.out_samples_valid;
    assign w_start      = (r_state == ST_IDLE) && !r_swapping && r_pend_v;
    assign w_fade_step  = w_accept_in && r_swapping;
    // A request for the already-selected pipeline only matters while a fade is running
    assign w_req_ok     = bus.swap_pipelines && (int'(bus.swap_target) < N_PIPELINES) &&
                          (r_swapping || (bus.swap_target != r_current));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: input wins over output when both strobe together
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_sample_valid)        w_state_nxt = ST_IN_MUL;
                else if (bus.out_samples_valid) w_state_nxt = ST_OUT_MUL;
            end
            ST_IN_MUL:   w_state_nxt = ST_IN_SAT;
            ST_IN_SAT:   w_state_nxt = ST_GAP;
            ST_OUT_MUL:  w_state_nxt = ST_OUT_SUM;
            ST_OUT_SUM:  w_state_nxt = ST_OUT_GAIN;
            ST_OUT_GAIN: w_state_nxt = ST_GAP;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Output-path multiplier operand select: channel A, channel B, then output gain
    always_comb begin
        w_mul_x = r_ch_a;
        w_mul_y = r_g_a;
        case (r_state)
            ST_OUT_SUM:  begin w_mul_x = r_ch_b; w_mul_y = r_g_b; end
            ST_OUT_GAIN: begin w_mul_x = r_sum;  w_mul_y = r_og;  end
            default:     ;
        endcase
    end

    assign w_out_prod = w_mul_x * w_mul_y;
    assign w_out_sat  = sat_prod(w_out_prod);
    assign w_sum_wide = {r_part_a[DATA_WIDTH-1], r_part_a} + {w_out_sat[DATA_WIDTH-1], w_out_sat};

    // Datapath: operands are captured in IDLE so later gain writes do not disturb a sample in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_x      <= '0;
            r_in_g      <= '0;
            r_in_prod   <= '0;
            r_in_out    <= '0;
            r_in_ready  <= 1'b0;
            r_ch_a      <= '0;
            r_ch_b      <= '0;
            r_g_a       <= '0;
            r_g_b       <= '0;
            r_og        <= '0;
            r_part_a    <= '0;
            r_sum       <= '0;
            r_out       <= '0;
            r_out_ready <= 1'b0;
        end else begin
            r_in_ready  <= 1'b0;
            r_out_ready <= 1'b0;
            if (w_accept_in) begin
                r_in_x <= bus.in_sample;
                r_in_g <= r_in_gain;
            end
            if (r_state == ST_IN_MUL) r_in_prod <= r_in_x * r_in_g;
            if (r_state == ST_IN_SAT) begin
                r_in_out   <= sat_prod(r_in_prod);
                r_in_ready <= 1'b1;
            end
            if (w_accept_out) begin
                r_ch_a <= w_ch[r_current];
                r_ch_b <= w_ch[r_target];
                r_g_a  <= r_gcur;
                r_g_b  <= r_gtgt;
                r_og   <= r_out_gain;
            end
            if (r_state == ST_OUT_MUL) r_part_a <= w_out_sat;
            if (r_state == ST_OUT_SUM) r_sum    <= sat_sum(w_sum_wide);
            if (r_state == ST_OUT_GAIN) begin
                r_out       <= w_out_sat;
                r_out_ready <= 1'b1;
            end
        end
    end

    // Swap request latch and crossfade stepping (one step per accepted input sample)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_current  <= '0;
            r_target   <= '0;
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_swapping <= 1'b0;
            r_gcur     <= c_unity;
            r_gtgt     <= '0;
        end else begin
            if (w_start) begin
                r_target   <= r_pend;
                r_swapping <= 1'b1;
                r_pend_v   <= 1'b0;
            end
            // A fresh request lands after the start so it becomes the next pending fade
            if (w_req_ok) begin
                r_pend   <= bus.swap_target;
                r_pend_v <= 1'b1;
            end
            if (w_fade_step) begin
                if (r_gcur <= c_step) begin
                    r_current  <= r_target;
                    r_gcur     <= c_unity;
                    r_gtgt     <= '0;
                    r_swapping <= 1'b0;
                end else begin
                    r_gcur <= r_gcur - c_step;
                    r_gtgt <= r_gtgt + c_step;
                end
            end
        end
    end

`ifdef MULTI_PIPELINE_MIXER_SOFT_GAIN_EN
    logic signed [DATA_WIDTH-1:0] r_in_gain_tgt, r_out_gain_tgt;

    // Move one step toward the target, landing exactly on it for the last step
    function automatic logic signed [DATA_WIDTH-1:0] step_toward(
        input logic signed [DATA_WIDTH-1:0] cur,
        input logic signed [DATA_WIDTH-1:0] tgt
    );
        logic signed [DATA_WIDTH:0] diff;
        diff = $signed({tgt[DATA_WIDTH-1], tgt}) - $signed({cur[DATA_WIDTH-1], cur});
        if (diff > $signed({1'b0, c_step}))       return cur + c_step;
        else if (diff < -$signed({1'b0, c_step})) return cur - c_step;
        else                                      return tgt;
    endfunction

    // Gain writes set targets; effective gains glide per accepted input sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_gain      <= c_unity;
            r_out_gain     <= c_unity;
            r_in_gain_tgt  <= c_unity;
            r_out_gain_tgt <= c_unity;
        end else begin
            if (bus.set_input_gain)  r_in_gain_tgt  <= bus.data_in;
            if (bus.set_output_gain) r_out_gain_tgt <= bus.data_in;
            if (w_accept_in) begin
                r_in_gain  <= step_toward(r_in_gain, r_in_gain_tgt);
                r_out_gain <= step_toward(r_out_gain, r_out_gain_tgt);
            end
        end
    end
`else
    // Gain writes load the effective gains directly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_gain  <= c_unity;
            r_out_gain <= c_unity;
        end else begin
            if (bus.set_input_gain)  r_in_gain  <= bus.data_in;
            if (bus.set_output_gain) r_out_gain <= bus.data_in;
        end
    end
`endif

    assign bus.in_sample_out      = r_in_out;
    assign bus.in_sample_ready    = r_in_ready;
    assign bus.out_sample         = r_out;
    assign bus.out_sample_ready   = r_out_ready;
    assign bus.pipelines_swapping = r_swapping;
    assign bus.current_pipeline   = r_current;

endmodule
`default_nettype wire

// File: tb/tb_multi_pipeline_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_pipeline_mixer
//  Description : Self-checking bench for multi_pipeline_mixer against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pipeline_mixer;
    localparam int DATA_WIDTH  = 16;
    localparam int GAIN_SHIFT  = 4;
    localparam int N_PIPELINES = 4;
    localparam int SEL_WIDTH   = 2;
    localparam int FADE_SHIFT  = 7;
    localparam int c_frac      = DATA_WIDTH - 1 - GAIN_SHIFT;
    localparam int c_unity     = 1 << c_frac;
    localparam int c_step      = c_unity >> FADE_SHIFT;
    localparam int c_fade_len  = c_unity / c_step;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    multi_pipeline_mixer_if #(.DATA_WIDTH(DATA_WIDTH), .N_PIPELINES(N_PIPELINES), .SEL_WIDTH(SEL_WIDTH)) bus();

    multi_pipeline_mixer #(
        .DATA_WIDTH(DATA_WIDTH), .GAIN_SHIFT(GAIN_SHIFT), .N_PIPELINES(N_PIPELINES),
        .SEL_WIDTH(SEL_WIDTH), .FADE_SHIFT(FADE_SHIFT)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_in_gain, m_out_gain, m_cur, m_tgt, m_pend, m_fade_k;
    bit m_sw, m_pv;
    int m_ch [N_PIPELINES];

    task automatic check_value(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sat_w(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Fixed-point multiply with floor rounding and saturation
    function automatic int gain_mul(input int x, input int g);
        return sat_w((longint'(x) * longint'(g)) >>> c_frac);
    endfunction

    function automatic int model_output();
        int gc, gt, a, b, s;
        gc = c_unity - c_step * m_fade_k;
        gt = c_step * m_fade_k;
        a  = gain_mul(m_ch[m_cur], gc);
        b  = gain_mul(m_ch[m_tgt], gt);
        s  = sat_w(longint'(a) + longint'(b));
        return gain_mul(s, m_out_gain);
    endfunction

    task automatic model_reset();
        m_in_gain = c_unity; m_out_gain = c_unity;
        m_cur = 0; m_tgt = 0; m_pend = 0; m_fade_k = 0;
        m_sw = 1'b0; m_pv = 1'b0;
    endtask

    // Model effect of one clock edge seen while the mixer is idle
    task automatic model_idle_edge(input bit acc_in, input bit req, input int t);
        bit old_sw  = m_sw;
        bit old_pv  = m_pv;
        int old_p   = m_pend;
        int old_cur = m_cur;
        if (acc_in && old_sw) begin
            m_fade_k++;
            if (m_fade_k == c_fade_len) begin
                m_cur = m_tgt; m_sw = 1'b0; m_fade_k = 0;
            end
        end
        if (!old_sw && old_pv) begin
            m_tgt = old_p; m_sw = 1'b1; m_pv = 1'b0;
        end
        if (req && t < N_PIPELINES && !(t == old_cur && !old_sw)) begin
            m_pend = t; m_pv = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ch();
        for (int k = 0; k < N_PIPELINES; k++) m_ch[k] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic drive_ch();
        for (int k = 0; k < N_PIPELINES; k++)
            bus.out_samples_in[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(m_ch[k]);
    endtask

    task automatic idle_cycle();
        model_idle_edge(1'b0, 1'b0, 0);
        tick();
    endtask

    task automatic run_input(input int x, input bit also_out);
        int exp_v;
        exp_v = gain_mul(x, m_in_gain);
        bus.in_sample       = DATA_WIDTH'(x);
        bus.in_sample_valid = 1'b1;
        if (also_out) begin
            drive_ch();
            bus.out_samples_valid = 1'b1;
        end
        model_idle_edge(1'b1, 1'b0, 0);
        tick();
        bus.in_sample_valid   = 1'b0;
        bus.out_samples_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_value("in_ready_timing", longint'(bus.in_sample_ready), longint'(c == 3));
            check_value("out_ready_quiet", longint'(bus.out_sample_ready), 0);
            if (c == 3) check_value("in_sample_out", longint'(bus.in_sample_out), exp_v);
            if (c < 4) tick();
        end
    endtask

    task automatic run_output();
        int exp_v;
        exp_v = model_output();
        drive_ch();
        bus.out_samples_valid = 1'b1;
        model_idle_edge(1'b0, 1'b0, 0);
        tick();
        bus.out_samples_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_value("out_ready_timing", longint'(bus.out_sample_ready), longint'(c == 4));
            check_value("in_ready_quiet", longint'(bus.in_sample_ready), 0);
            if (c == 4) check_value("out_sample", longint'(bus.out_sample), exp_v);
            if (c < 5) tick();
        end
    endtask

    task automatic swap_request(input int t);
        bus.swap_pipelines = 1'b1;
        bus.swap_target    = SEL_WIDTH'(t);
        model_idle_edge(1'b0, 1'b1, t);
        tick();
        bus.swap_pipelines = 1'b0;
        idle_cycle();
    endtask

    task automatic set_gain(input bit to_out, input int g);
        bus.data_in = DATA_WIDTH'(g);
        if (to_out) bus.set_output_gain = 1'b1;
        else        bus.set_input_gain  = 1'b1;
        model_idle_edge(1'b0, 1'b0, 0);
        tick();
        bus.set_output_gain = 1'b0;
        bus.set_input_gain  = 1'b0;
        if (to_out) m_out_gain = g;
        else        m_in_gain  = g;
    endtask

    task automatic check_fade_state(input string tag);
        check_value({tag, "_swapping"}, longint'(bus.pipelines_swapping), longint'(m_sw));
        check_value({tag, "_current"}, longint'(bus.current_pipeline), m_cur);
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        rst                   = 1'b1;
        bus.in_sample         = '0;
        bus.in_sample_valid   = 1'b0;
        bus.out_samples_in    = '0;
        bus.out_samples_valid = 1'b0;
        bus.data_in           = '0;
        bus.set_input_gain    = 1'b0;
        bus.set_output_gain   = 1'b0;
        bus.swap_pipelines    = 1'b0;
        bus.swap_target       = '0;
        model_reset();
        repeat (3) tick();

        check_value("rst_in_sample_out", longint'(bus.in_sample_out), 0);
        check_value("rst_out_sample", longint'(bus.out_sample), 0);
        check_value("rst_in_ready", longint'(bus.in_sample_ready), 0);
        check_value("rst_out_ready", longint'(bus.out_sample_ready), 0);
        check_fade_state("rst");
        rst = 1'b0;
        tick();

        // Unity gain pass-through, then 2.0 gain saturating both ways
        run_input(32'h1000, 1'b0);
        set_gain(1'b0, 32'h1000);
        run_input(32'h5000, 1'b0);
        run_input(-32'sh5000, 1'b0);
        set_gain(1'b0, c_unity);

        // Request for the already-selected pipeline is ignored
        swap_request(0);
        check_fade_state("same_target");

        // Fade 0 -> 1 with known channel values
        rand_ch();
        m_ch[0] = 32'h2000;
        m_ch[1] = 32'h4000;
        run_output();
        swap_request(1);
        repeat (64) run_input(rand_sample(), 1'b0);
        check_fade_state("half_fade");
        run_output();
        repeat (64) run_input(rand_sample(), 1'b0);
        check_fade_state("fade_done");
        run_output();

        // Queued request during a running fade
        swap_request(1);
        check_fade_state("same_target2");
        swap_request(2);
        repeat (40) run_input(rand_sample(), 1'b0);
        swap_request(3);
        rand_ch();
        run_output();
        repeat (88) run_input(rand_sample(), 1'b0);
        check_fade_state("fade2_done");
        idle_cycle();
        check_fade_state("fade3_start");
        repeat (128) run_input(rand_sample(), 1'b0);
        check_fade_state("fade3_done");
        run_output();

        // Simultaneous strobes: input wins, output strobe dropped
        rand_ch();
        run_input(rand_sample(), 1'b1);
        run_input(rand_sample(), 1'b1);

        // Randomized mix of operations
        for (int i = 0; i < 120; i++) begin
            int op;
            op = int'($urandom_range(0, 11));
            if (op <= 4)       run_input(rand_sample(), 1'b0);
            else if (op <= 7)  begin rand_ch(); run_output(); end
            else if (op == 8)  set_gain(1'($urandom_range(0, 1)), int'($urandom_range(0, 32'h2000)) - 32'h0800);
            else if (op == 9)  swap_request(int'($urandom_range(0, N_PIPELINES - 1)));
            else if (op == 10) repeat (20) run_input(rand_sample(), 1'b0);
            else               idle_cycle();
        end
        check_fade_state("random_end");

        // Reset mid-fade with a pending request and an output transaction in flight
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        swap_request(2);
        repeat (10) run_input(rand_sample(), 1'b0);
        swap_request(3);
        check_fade_state("pre_reset");
        rand_ch();
        drive_ch();
        bus.out_samples_valid = 1'b1;
        tick();
        bus.out_samples_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            check_value("abort_out_ready", longint'(bus.out_sample_ready), 0);
            tick();
        end
        check_value("abort_out_sample", longint'(bus.out_sample), 0);
        check_fade_state("post_reset");
        idle_cycle();
        check_fade_state("pending_cleared");
        run_output();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
